// File: rtl/mem_burst_master.sv
// Burst read/write initiator driving a single-port synchronous word memory.
// Define MEMBM_ADDR_CHECK_EN to reject commands whose start address is >= MEM_DEPTH.
module mem_burst_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 8,
  parameter int LEN_W     = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic              Cmd_RW,
  input  logic [ADDR_W-1:0] Cmd_Addr,
  input  logic [LEN_W-1:0]  Cmd_Len,
  input  logic [DATA_W-1:0] Wr_Data,
  input  logic              Wr_Valid,
  output logic              Wr_Ready,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Rd_Valid,
  output logic              Rd_Last,
  output logic [DATA_W-1:0] Mem_Din,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_R_W,
  output logic              Mem_Valid,
  input  logic [DATA_W-1:0] Mem_Dout,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_r_w_q, mem_r_w_d;
  logic              mem_valid_q, mem_valid_d;
  logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              wr_ready_q, wr_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              addr_bad;

`ifdef MEMBM_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);
  logic err_q, err_d;
  assign addr_bad = ({1'b0, Cmd_Addr} >= DEPTH_EXT);
  assign Err      = err_q;
`else
  assign addr_bad = 1'b0;
  assign Err      = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    mem_din_d   = mem_din_q;
    mem_addr_d  = mem_addr_q;
    mem_r_w_d   = 1'b0;
    mem_valid_d = 1'b0;
    s1_valid_d  = 1'b0;
    s1_last_d   = 1'b0;
    s2_valid_d  = s1_valid_q;
    s2_last_d   = s1_last_q;
    rd_valid_d  = s2_valid_q;
    rd_last_d   = s2_last_q;
    rd_data_d   = s2_valid_q ? Mem_Dout : rd_data_q;
`ifdef MEMBM_ADDR_CHECK_EN
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (Cmd_Valid && cmd_ready_q) begin
          rem_d = Cmd_Len;
          if (addr_bad) begin
            state_d = DONE;
`ifdef MEMBM_ADDR_CHECK_EN
            err_d   = 1'b1;
`endif
          end else if (Cmd_RW) begin
            cur_d   = Cmd_Addr;
            state_d = WRITE;
          end else begin
            // First read is issued on the accept edge so Mem_Addr=A shows in cycle 1.
            mem_valid_d = 1'b1;
            mem_addr_d  = Cmd_Addr;
            s1_valid_d  = 1'b1;
            s1_last_d   = (Cmd_Len == '0);
            cur_d       = next_addr(Cmd_Addr);
            state_d     = (Cmd_Len == '0) ? DRAIN : READ;
          end
        end
      end
      WRITE: begin
        if (Wr_Valid && wr_ready_q) begin
          mem_r_w_d   = 1'b1;
          mem_valid_d = 1'b1;
          mem_addr_d  = cur_q;
          mem_din_d   = Wr_Data;
          cur_d       = next_addr(cur_q);
          if (rem_q == '0) state_d = DRAIN;
          else             rem_d   = rem_q - 1'b1;
        end
      end
      READ: begin
        mem_valid_d = 1'b1;
        mem_addr_d  = cur_q;
        s1_valid_d  = 1'b1;
        s1_last_d   = (rem_q == LEN_W'(1));
        cur_d       = next_addr(cur_q);
        rem_d       = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        // Writes pass through here too, so Done follows the final memory write cycle.
        if (!s1_valid_q && !s2_valid_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == WRITE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      mem_din_q   <= '0;
      mem_addr_q  <= '0;
      mem_r_w_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEMBM_ADDR_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      mem_din_q   <= mem_din_d;
      mem_addr_q  <= mem_addr_d;
      mem_r_w_q   <= mem_r_w_d;
      mem_valid_q <= mem_valid_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MEMBM_ADDR_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign Cmd_Ready = cmd_ready_q & Reset_n;
  assign Wr_Ready  = wr_ready_q;
  assign Rd_Data   = rd_data_q;
  assign Rd_Valid  = rd_valid_q;
  assign Rd_Last   = rd_last_q;
  assign Mem_Din   = mem_din_q;
  assign Mem_Addr  = mem_addr_q;
  assign Mem_R_W   = mem_r_w_q;
  assign Mem_Valid = mem_valid_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed plus randomized bench for mem_burst_master with a behavioural memory and reference array.
module tb_mem_burst_master;

  logic        Clk;
  logic        Reset_n;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic        Cmd_RW;
  logic [7:0]  Cmd_Addr;
  logic [3:0]  Cmd_Len;
  logic [31:0] Wr_Data;
  logic        Wr_Valid;
  logic        Wr_Ready;
  logic [31:0] Rd_Data;
  logic        Rd_Valid;
  logic        Rd_Last;
  logic [31:0] Mem_Din;
  logic [7:0]  Mem_Addr;
  logic        Mem_R_W;
  logic        Mem_Valid;
  logic [31:0] Mem_Dout;
  logic        Busy;
  logic        Done;
  logic        Err;

  int n_cmp = 0;
  int n_err = 0;
  int rw_cnt = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:7];
  logic [31:0] wdata   [0:15];

  mem_burst_master dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_RW(Cmd_RW),
    .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len),
    .Wr_Data(Wr_Data), .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready),
    .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Rd_Last(Rd_Last),
    .Mem_Din(Mem_Din), .Mem_Addr(Mem_Addr), .Mem_R_W(Mem_R_W), .Mem_Valid(Mem_Valid),
    .Mem_Dout(Mem_Dout),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Memory instance: writes on every edge with R_W=1, registered read data.
  always @(posedge Clk) begin
    if (Mem_R_W === 1'b1) mem[Mem_Addr] <= Mem_Din;
    if (Mem_Valid === 1'b1 && Mem_R_W === 1'b0) Mem_Dout <= mem[Mem_Addr];
  end

  always @(posedge Clk) if (Mem_R_W === 1'b1) rw_cnt <= rw_cnt + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command and wait (bounded) for the cycle in which it is accepted.
  task automatic issue_cmd(input logic rw, input int a, input int l, input int max_wait);
    int waits = 0;
    Cmd_Valid = 1'b1;
    Cmd_RW    = rw;
    Cmd_Addr  = 8'(a);
    Cmd_Len   = 4'(l);
    while (Cmd_Ready !== 1'b1 && waits < 20) begin
      tick();
      waits++;
    end
    check1("cmd_accept_wait", waits <= max_wait, 1'b1);
  endtask

  task automatic write_burst(input int a, input int l, input int gap);
    issue_cmd(1'b1, a, l, 20);
    tick();
    Cmd_Valid = 1'b0;
    check1("wr_busy", Busy, 1'b1);
    for (int i = 0; i <= l; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          Wr_Valid = 1'b0;
          tick();
          check1("wr_gap_rw", Mem_R_W, 1'b0);
        end
      end
      check1("wr_ready", Wr_Ready, 1'b1);
      Wr_Valid = 1'b1;
      Wr_Data  = wdata[i];
      tick();
      Wr_Valid = 1'b0;
      check1("wr_rw", Mem_R_W, 1'b1);
      check1("wr_valid", Mem_Valid, 1'b1);
      checkw("wr_addr", 32'(Mem_Addr), 32'((a + i) % 8));
      checkw("wr_din", Mem_Din, wdata[i]);
      ref_mem[(a + i) % 8] = wdata[i];
    end
    check1("wr_ready_drop", Wr_Ready, 1'b0);
    check1("wr_done_early", Done, 1'b0);
    tick();
    check1("wr_done", Done, 1'b1);
    check1("wr_rw_off", Mem_R_W, 1'b0);
    tick();
    check1("wr_idle_done", Done, 1'b0);
    check1("wr_idle_busy", Busy, 1'b0);
    check1("wr_idle_ready", Cmd_Ready, 1'b1);
    $display("write a=%0d len=%0d gap=%0d", a, l, gap);
  endtask

  // Read burst; optionally keeps Cmd_Valid high with a follow-on read command.
  task automatic read_burst(input int a, input int l, input bit hold, input int na, input int nl,
                            input int max_wait);
    issue_cmd(1'b0, a, l, max_wait);
    for (int c = 1; c <= l + 4; c++) begin
      tick();
      if (c == 1) begin
        if (hold) begin
          Cmd_RW   = 1'b0;
          Cmd_Addr = 8'(na);
          Cmd_Len  = 4'(nl);
        end else begin
          Cmd_Valid = 1'b0;
        end
      end
      check1("rd_cmd_ready", Cmd_Ready, 1'b0);
      if (c <= l + 1) begin
        check1("rd_mem_valid", Mem_Valid, 1'b1);
        check1("rd_mem_rw", Mem_R_W, 1'b0);
        checkw("rd_mem_addr", 32'(Mem_Addr), 32'((a + c - 1) % 8));
      end
      if (c == l + 2) check1("rd_mem_idle", Mem_Valid, 1'b0);
      if (c >= 3 && c <= l + 3) begin
        check1("rd_valid", Rd_Valid, 1'b1);
        checkw("rd_data", Rd_Data, ref_mem[(a + c - 3) % 8]);
        check1("rd_last", Rd_Last, c == l + 3);
      end else begin
        check1("rd_valid_off", Rd_Valid, 1'b0);
      end
      check1("rd_done", Done, c == l + 4);
    end
    check1("rd_err", Err, 1'b0);
    tick();
    check1("rd_idle_busy", Busy, 1'b0);
    check1("rd_idle_done", Done, 1'b0);
    check1("rd_idle_valid", Rd_Valid, 1'b0);
    check1("rd_idle_ready", Cmd_Ready, 1'b1);
    $display("read a=%0d len=%0d hold=%0d", a, l, hold);
  endtask

  initial begin
    int rw0;
    int ra, rl, rg;
    Reset_n   = 1'b0;
    Cmd_Valid = 1'b0;
    Cmd_RW    = 1'b0;
    Cmd_Addr  = '0;
    Cmd_Len   = '0;
    Wr_Data   = '0;
    Wr_Valid  = 1'b0;
    repeat (3) tick();

    check1("rst_rw", Mem_R_W, 1'b0);
    check1("rst_mvalid", Mem_Valid, 1'b0);
    checkw("rst_maddr", 32'(Mem_Addr), 32'd0);
    checkw("rst_mdin", Mem_Din, 32'd0);
    check1("rst_rvalid", Rd_Valid, 1'b0);
    check1("rst_rlast", Rd_Last, 1'b0);
    checkw("rst_rdata", Rd_Data, 32'd0);
    check1("rst_done", Done, 1'b0);
    check1("rst_err", Err, 1'b0);
    check1("rst_busy", Busy, 1'b0);
    check1("rst_cmd_ready", Cmd_Ready, 1'b0);
    Reset_n = 1'b1;
    tick();
    check1("rel_cmd_ready", Cmd_Ready, 1'b1);
    $display("reset released");

    // Back-to-back write then read of four known words.
    wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;
    write_burst(2, 3, 0);
    read_burst(2, 3, 1'b0, 0, 0, 0);

    // Two beats separated by idle write-stream cycles.
    for (int i = 0; i < 16; i++) wdata[i] = $urandom;
    rw0 = rw_cnt;
    write_burst(5, 1, 2);
    checkw("rw_pulses", 32'(rw_cnt - rw0), 32'd2);
    read_burst(5, 1, 1'b0, 0, 0, 0);

    // Address wrap 6,7,0,1.
    for (int i = 0; i < 16; i++) wdata[i] = $urandom;
    write_burst(6, 3, 0);
    read_burst(6, 3, 1'b0, 0, 0, 0);

`ifdef MEMBM_ADDR_CHECK_EN
    rw0 = rw_cnt;
    issue_cmd(1'b1, 9, 2, 20);
    tick();
    Cmd_Valid = 1'b0;
    check1("err_pulse", Err, 1'b1);
    check1("err_done", Done, 1'b1);
    check1("err_mvalid", Mem_Valid, 1'b0);
    check1("err_rw", Mem_R_W, 1'b0);
    tick();
    check1("err_clear", Err, 1'b0);
    check1("err_done_clear", Done, 1'b0);
    check1("err_ready", Cmd_Ready, 1'b1);
    checkw("err_no_write", 32'(rw_cnt - rw0), 32'd0);
    $display("rejected command a=9");
`endif

    // Reset in the middle of a write burst after two beats.
    for (int i = 0; i < 16; i++) wdata[i] = $urandom;
    issue_cmd(1'b1, 3, 3, 20);
    tick();
    Cmd_Valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Wr_Valid = 1'b1;
      Wr_Data  = wdata[i];
      tick();
      Wr_Valid = 1'b0;
      check1("rstw_rw", Mem_R_W, 1'b1);
      ref_mem[(3 + i) % 8] = wdata[i];
    end
    Reset_n = 1'b0;
    tick();
    check1("rstw_rw_off", Mem_R_W, 1'b0);
    check1("rstw_busy", Busy, 1'b0);
    check1("rstw_done", Done, 1'b0);
    check1("rstw_cmd_ready_low", Cmd_Ready, 1'b0);
    Reset_n = 1'b1;
    tick();
    check1("rstw_cmd_ready", Cmd_Ready, 1'b1);
    check1("rstw_done2", Done, 1'b0);
    tick();
    check1("rstw_done3", Done, 1'b0);
    $display("reset mid-burst a=3 after 2 beats");
    read_burst(3, 1, 1'b0, 0, 0, 0);

    // Second command held during a burst; it must wait for the IDLE cycle after Done.
    read_burst(2, 3, 1'b1, 6, 0, 0);
    read_burst(6, 0, 1'b0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      ra = int'($urandom_range(0, 7));
      rl = int'($urandom_range(0, 15));
      rg = int'($urandom_range(0, 2));
      for (int i = 0; i < 16; i++) wdata[i] = $urandom;
      write_burst(ra, rl, rg);
      ra = int'($urandom_range(0, 7));
      rl = int'($urandom_range(0, 9));
      read_burst(ra, rl, 1'b0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
